// File: rtl/key_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_pkg
// Description : Shared types and constants for the keyboard matrix scanner:
//               FSM state encoding, default matrix addresses and the width
//               of a queued key-code entry {control, shift, code}.
// Revision    : 1.0 - initial release
// ============================================================================
package key_scan_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        DOWN     = 2'd2,
        RELEASE  = 2'd3
    } keyState_t;

    localparam int c_DEF_KEY_BITS   = 6;
    localparam int c_DEF_DEB_SCANS  = 2;
    localparam int c_DEF_FIFO_DEPTH = 4;
    localparam int c_DEF_CTRL_ADDR  = 0;
    localparam int c_DEF_SHIFT_ADDR = 16;
    localparam int c_DEF_BREAK_ADDR = 48;

    // Entry layout is {control, shift, scan code}.
    function automatic int entryWidth(input int keyBits);
        return keyBits + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_ctrl_if
// Description : Matrix-side and CPU-side signals of the keyboard scanner.
//               master = scanner core, slave = matrix / register logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_scan_ctrl_if
    import key_scan_pkg::*;
#(
    parameter int KEY_BITS = c_DEF_KEY_BITS
);
    logic                              scanTick;
    logic                              scanEn;
    logic                              debEn;
    logic                              KR1;
    logic                              KR2;
    logic [KEY_BITS-1:0]               K;
    logic                              keyDown;
    logic                              kShift;
    logic                              setKey;
    logic                              setBreak;
    logic                              rdEn;
    logic                              ovrClr;
    logic [entryWidth(KEY_BITS)-1:0]   D;
    logic [4:0]                        count;
    logic                              overrun;

    modport master (
        input  scanTick, scanEn, debEn, KR1, KR2, rdEn, ovrClr,
        output K, keyDown, kShift, setKey, setBreak, D, count, overrun
    );

    modport slave (
        output scanTick, scanEn, debEn, KR1, KR2, rdEn, ovrClr,
        input  K, keyDown, kShift, setKey, setBreak, D, count, overrun
    );
endinterface
`default_nettype wire

// File: rtl/key_code_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_code_fifo
// Description : Small power-of-two FIFO for accepted key codes. A push when
//               full is dropped unless a pop happens in the same cycle; a pop
//               when empty is ignored. popData is the raw head slot.
// Revision    : 1.0 - initial release
// ============================================================================
module key_code_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty,
    output logic [4:0]       count
);
    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [4:0]         r_count;
    logic               w_doPop;
    logic               w_doPush;

    assign empty    = (r_count == 5'd0);
    assign full     = (r_count == 5'(DEPTH));
    assign w_doPop  = pop & ~empty;
    // A pop frees the head slot this cycle, so a full FIFO still takes the push.
    assign w_doPush = push & (~full | w_doPop);
    assign popData  = r_mem[r_rdPtr];
    assign count    = r_count;

    // Storage write; no reset needed since reads are qualified by empty.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= pushData;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= 5'd0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + c_PTR_ONE;
            if (w_doPop)  r_rdPtr <= r_rdPtr + c_PTR_ONE;
            if (w_doPush && !w_doPop)      r_count <= r_count + 5'd1;
            else if (w_doPop && !w_doPush) r_count <= r_count - 5'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/key_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_ctrl
// Description : Keyboard matrix scanner. Free-running decrementing scan
//               address, per-key debounce FSM, shift/control tracking,
//               break-edge detection and a key-code queue for the CPU.
//               Build option KEY_SCAN_FIFO_EN: FIFO_DEPTH-entry queue;
//               undefined gives a single POKEY-style holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module key_scan_ctrl
    import key_scan_pkg::*;
#(
    parameter int KEY_BITS   = c_DEF_KEY_BITS,
    parameter int DEB_SCANS  = c_DEF_DEB_SCANS,
    parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH,
    parameter int CTRL_ADDR  = c_DEF_CTRL_ADDR,
    parameter int SHIFT_ADDR = c_DEF_SHIFT_ADDR,
    parameter int BREAK_ADDR = c_DEF_BREAK_ADDR
) (
    input  logic           clk,
    input  logic           rst_n,
    key_scan_ctrl_if.master bus
);
    localparam int                  c_EW     = entryWidth(KEY_BITS);
    localparam logic [KEY_BITS-1:0] c_CTRL_A = KEY_BITS'(CTRL_ADDR);
    localparam logic [KEY_BITS-1:0] c_SHFT_A = KEY_BITS'(SHIFT_ADDR);
    localparam logic [KEY_BITS-1:0] c_BRK_A  = KEY_BITS'(BREAK_ADDR);

    if ((DEB_SCANS < 1) || (DEB_SCANS > 15)) begin : g_badDebScans
        $error("DEB_SCANS must be 1..15");
    end
    if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_badFifoDepth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end

    logic [KEY_BITS-1:0] r_scanCnt;
    logic [KEY_BITS-1:0] r_cmp;
    logic [3:0]          r_deb;
    keyState_t           r_state;
    logic                r_control;
    logic                r_shift;
    logic                r_breakDown;
    logic                r_setKey;
    logic                r_setBreak;
    logic                r_overrun;
    logic                w_hit;
    logic                w_fast;
    logic                w_debDone;
    logic                w_accept;
    logic                w_newOvr;
    logic [c_EW-1:0]     w_entry;
    logic [c_EW-1:0]     w_head;
    logic [4:0]          w_count;

    assign w_hit     = (r_scanCnt == r_cmp);
    assign w_fast    = ~bus.debEn | (DEB_SCANS == 1);
    assign w_debDone = ((r_deb + 4'd1) == 4'(DEB_SCANS));
    // The accepted code always equals the current address: in IDLE it is the
    // detection address, in DEBOUNCE acceptance requires K==cmp.
    assign w_entry   = {r_control, r_shift, r_scanCnt};
    assign w_accept  = bus.scanEn & bus.scanTick & ~bus.KR1 &
                       (((r_state == IDLE) & w_fast) |
                        ((r_state == DEBOUNCE) & w_hit & w_debDone));

    // Scan counter, modifier/break sampling and the per-key debounce FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scanCnt   <= '1;
            r_cmp       <= '0;
            r_deb       <= 4'd0;
            r_state     <= IDLE;
            r_control   <= 1'b0;
            r_shift     <= 1'b0;
            r_breakDown <= 1'b0;
            r_setKey    <= 1'b0;
            r_setBreak  <= 1'b0;
        end else begin
            r_setKey   <= w_accept;
            r_setBreak <= 1'b0;
            if (!bus.scanEn) begin
                r_scanCnt   <= '1;
                r_state     <= IDLE;
                r_deb       <= 4'd0;
                r_control   <= 1'b0;
                r_shift     <= 1'b0;
                r_breakDown <= 1'b0;
            end else if (bus.scanTick) begin
                r_scanCnt <= r_scanCnt - 1'b1;
                if (r_scanCnt == c_CTRL_A) r_control <= ~bus.KR2;
                if (r_scanCnt == c_SHFT_A) r_shift   <= ~bus.KR2;
                if (r_scanCnt == c_BRK_A) begin
                    r_setBreak  <= ~bus.KR2 & ~r_breakDown;
                    r_breakDown <= ~bus.KR2;
                end
                case (r_state)
                    IDLE: begin
                        if (!bus.KR1) begin
                            r_cmp   <= r_scanCnt;
                            r_deb   <= 4'd1;
                            r_state <= w_fast ? DOWN : DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_hit) begin
                            if (bus.KR1) begin
                                r_state <= IDLE;
                            end else begin
                                r_deb <= r_deb + 4'd1;
                                if (w_debDone) r_state <= DOWN;
                            end
                        end
                    end
                    DOWN: begin
                        if (w_hit && bus.KR1) r_state <= RELEASE;
                    end
                    RELEASE: begin
                        if (w_hit) r_state <= bus.KR1 ? IDLE : DOWN;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef KEY_SCAN_FIFO_EN
    logic            w_full;
    logic            w_empty;
    logic [c_EW-1:0] w_fifoHead;

    key_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_EW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_accept),
        .pushData (w_entry),
        .pop      (bus.rdEn),
        .popData  (w_fifoHead),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    assign w_head   = w_empty ? '0 : w_fifoHead;
    assign w_newOvr = w_accept & w_full & ~bus.rdEn;
`else
    logic [c_EW-1:0] r_holdD;
    logic            r_holdCnt;

    // Single holding register: newest accept always wins, rdEn only marks it read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_holdD   <= '0;
            r_holdCnt <= 1'b0;
        end else if (w_accept) begin
            r_holdD   <= w_entry;
            r_holdCnt <= 1'b1;
        end else if (bus.rdEn) begin
            r_holdCnt <= 1'b0;
        end
    end

    assign w_head   = r_holdD;
    assign w_count  = {4'd0, r_holdCnt};
    assign w_newOvr = w_accept & r_holdCnt & ~bus.rdEn;
`endif

    // Sticky overrun; a new loss in the same cycle beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_overrun <= 1'b0;
        else        r_overrun <= (r_overrun & ~bus.ovrClr) | w_newOvr;
    end

    assign bus.K        = r_scanCnt;
    assign bus.keyDown  = (r_state == DOWN) || (r_state == RELEASE);
    assign bus.kShift   = r_shift;
    assign bus.setKey   = r_setKey;
    assign bus.setBreak = r_setBreak;
    assign bus.D        = w_head;
    assign bus.count    = w_count;
    assign bus.overrun  = r_overrun;
endmodule
`default_nettype wire
